// File: rtl/uart_pack.sv
// Shared definitions for the UART host-side FIFO controller.
package uart_pack;

   localparam int uart_width = 8;

   typedef enum logic [1:0] {
      TX_IDLE      = 2'd0,
      TX_START     = 2'd1,
      TX_WAIT_LOW  = 2'd2,
      TX_WAIT_HIGH = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO. A push into a full FIFO is
// accepted when a pop happens in the same cycle, because that pop frees
// the slot being written.
module uart_fifo
   import uart_pack::*;
#(
   parameter int DEPTH = 8,
   parameter int width = uart_width
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [width-1:0] data_i,
   input  logic             pop_i,
   output logic [width-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [width-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign w_pop   = pop_i & (r_count != '0);
   assign w_push  = push_i & ((r_count != FULL_CNT) | w_pop);
   assign data_o  = r_mem[r_rd_ptr];
   assign empty_o = (r_count == '0);
   assign full_o  = (r_count == FULL_CNT);

   // Storage write; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= data_i;
      end
   end

   // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Host-side buffering around the UART: a TX FIFO drained by a start/ready
// handshake FSM, and an RX FIFO filled on rising edges of the receiver's
// byte-ready level, with a sticky overrun flag.
//
// state        | meaning
// TX_IDLE      | waiting for a queued byte and an idle transmitter
// TX_START     | one-cycle start pulse; byte already latched on tx_data_o
// TX_WAIT_LOW  | waiting for the transmitter to report busy
// TX_WAIT_HIGH | waiting for the transmitter to return to idle
module uart_fifo_ctrl
   import uart_pack::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_valid_i,
   input  logic [uart_width-1:0] wr_data_i,
   output logic                  wr_ready_o,
   output logic                  rd_valid_o,
   output logic [uart_width-1:0] rd_data_o,
   input  logic                  rd_ready_i,
   output logic                  tx_start_o,
   output logic [uart_width-1:0] tx_data_o,
   input  logic                  tx_rdy_i,
   input  logic [uart_width-1:0] rx_data_i,
   input  logic                  rx_rdy_i,
   input  logic                  ovr_clr_i,
   output logic                  rx_overrun_o
);

   tx_state_t             r_tx_state;
   tx_state_t             w_tx_state_nxt;
   logic [uart_width-1:0] r_tx_data;
   logic                  r_rx_rdy_prev;
   logic                  r_rx_overrun;
   logic                  w_tx_full;
   logic                  w_tx_empty;
   logic [uart_width-1:0] w_tx_head;
   logic                  w_tx_push;
   logic                  w_tx_pop;
   logic                  w_rx_full;
   logic                  w_rx_empty;
   logic                  w_rx_capture;
   logic                  w_rd_pop;
   logic                  w_rx_drop;

   // Ready comes straight from registered occupancy, never from this cycle's pop.
   assign wr_ready_o = ~w_tx_full;
   assign w_tx_push  = wr_valid_i & ~w_tx_full;

   uart_fifo #(.DEPTH(DEPTH), .width(uart_width)) u_tx_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_tx_push),
      .data_i  (wr_data_i),
      .pop_i   (w_tx_pop),
      .data_o  (w_tx_head),
      .empty_o (w_tx_empty),
      .full_o  (w_tx_full)
   );

   // Next-state and head-pop decode for the transmit handshake.
   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_pop       = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            if (!w_tx_empty && tx_rdy_i) begin
               w_tx_state_nxt = TX_START;
               w_tx_pop       = 1'b1;
            end
         end
         TX_START:     w_tx_state_nxt = TX_WAIT_LOW;
         TX_WAIT_LOW:  if (!tx_rdy_i) w_tx_state_nxt = TX_WAIT_HIGH;
         TX_WAIT_HIGH: if (tx_rdy_i)  w_tx_state_nxt = TX_IDLE;
         default:      w_tx_state_nxt = TX_IDLE;
      endcase
   end

   // State register and transmit holding register, loaded as TX_START is entered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_tx_state <= TX_IDLE;
         r_tx_data  <= '0;
      end else begin
         r_tx_state <= w_tx_state_nxt;
         if (w_tx_pop) r_tx_data <= w_tx_head;
      end
   end

   assign tx_start_o = (r_tx_state == TX_START);
   assign tx_data_o  = r_tx_data;

   // A full RX FIFO still takes the byte when the host pops in the same cycle.
   assign w_rx_capture = rx_rdy_i & ~r_rx_rdy_prev;
   assign w_rd_pop     = rd_ready_i & ~w_rx_empty;
   assign w_rx_drop    = w_rx_capture & w_rx_full & ~w_rd_pop;
   assign rd_valid_o   = ~w_rx_empty;
   assign rx_overrun_o = r_rx_overrun;

   uart_fifo #(.DEPTH(DEPTH), .width(uart_width)) u_rx_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_rx_capture),
      .data_i  (rx_data_i),
      .pop_i   (rd_ready_i),
      .data_o  (rd_data_o),
      .empty_o (w_rx_empty),
      .full_o  (w_rx_full)
   );

   // Edge detect resets high so a level already present at release is ignored;
   // a fresh overrun wins over a clear in the same cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rx_rdy_prev <= 1'b1;
         r_rx_overrun  <= 1'b0;
      end else begin
         r_rx_rdy_prev <= rx_rdy_i;
         if (w_rx_drop)      r_rx_overrun <= 1'b1;
         else if (ovr_clr_i) r_rx_overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl with DEPTH=8.
module tb_uart_fifo_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       wr_valid_i;
   logic [7:0] wr_data_i;
   logic       wr_ready_o;
   logic       rd_valid_o;
   logic [7:0] rd_data_o;
   logic       rd_ready_i;
   logic       tx_start_o;
   logic [7:0] tx_data_o;
   logic       tx_rdy_i;
   logic [7:0] rx_data_i;
   logic       rx_rdy_i;
   logic       ovr_clr_i;
   logic       rx_overrun_o;

   int n_tests = 0;
   int n_fail  = 0;

   uart_fifo_ctrl #(.DEPTH(8)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .wr_valid_i   (wr_valid_i),
      .wr_data_i    (wr_data_i),
      .wr_ready_o   (wr_ready_o),
      .rd_valid_o   (rd_valid_o),
      .rd_data_o    (rd_data_o),
      .rd_ready_i   (rd_ready_i),
      .tx_start_o   (tx_start_o),
      .tx_data_o    (tx_data_o),
      .tx_rdy_i     (tx_rdy_i),
      .rx_data_i    (rx_data_i),
      .rx_rdy_i     (rx_rdy_i),
      .ovr_clr_i    (ovr_clr_i),
      .rx_overrun_o (rx_overrun_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Transmitter model: report idle, await the start pulse, then go busy and idle again.
   task automatic tx_handshake(input logic [7:0] exp_byte);
      bit seen;
      seen = 1'b0;
      tx_rdy_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (tx_start_o) begin
            seen = 1'b1;
            break;
         end
      end
      check("tx_start_seen", {31'd0, seen}, 32'd1);
      check("tx_data_order", {24'd0, tx_data_o}, {24'd0, exp_byte});
      tx_rdy_i = 1'b0;
      tick();
      check("tx_start_single", {31'd0, tx_start_o}, 32'd0);
      tick();
   endtask

   task automatic rx_deliver(input logic [7:0] b, input logic pop, input logic clr);
      rx_data_i  = b;
      rx_rdy_i   = 1'b1;
      rd_ready_i = pop;
      ovr_clr_i  = clr;
      tick();
      rx_rdy_i   = 1'b0;
      rd_ready_i = 1'b0;
      ovr_clr_i  = 1'b0;
      tick();
   endtask

   initial begin
      bit seen_start;
      rst_i = 1'b1; wr_valid_i = 1'b0; wr_data_i = 8'h00; rd_ready_i = 1'b0;
      tx_rdy_i = 1'b1; rx_data_i = 8'h00; rx_rdy_i = 1'b0; ovr_clr_i = 1'b0;
      tick(); tick();
      check("rst_tx_start", {31'd0, tx_start_o}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data_o}, 32'd0);
      check("rst_overrun", {31'd0, rx_overrun_o}, 32'd0);
      check("rst_rd_valid", {31'd0, rd_valid_o}, 32'd0);
      check("rst_wr_ready", {31'd0, wr_ready_o}, 32'd1);
      rst_i = 1'b0;
      tick();

      // Single byte: start one cycle after the push edge.
      wr_valid_i = 1'b1; wr_data_i = 8'hA5;
      tick();
      wr_valid_i = 1'b0;
      check("a5_no_early_start", {31'd0, tx_start_o}, 32'd0);
      check("a5_wr_ready", {31'd0, wr_ready_o}, 32'd1);
      tick();
      check("a5_start", {31'd0, tx_start_o}, 32'd1);
      check("a5_data", {24'd0, tx_data_o}, 32'h0000_00A5);
      tx_rdy_i = 1'b0;
      tick();
      check("a5_pulse_end", {31'd0, tx_start_o}, 32'd0);
      check("a5_data_hold", {24'd0, tx_data_o}, 32'h0000_00A5);
      tick();
      tx_rdy_i = 1'b1;
      tick(); tick();
      check("a5_no_restart", {31'd0, tx_start_o}, 32'd0);

      // Fill TX while the transmitter is busy, then drain in order.
      tx_rdy_i = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         wr_valid_i = 1'b1; wr_data_i = 8'(i);
         tick();
         if (i == 7) check("fill7_wr_ready", {31'd0, wr_ready_o}, 32'd1);
      end
      wr_valid_i = 1'b0;
      check("full_wr_ready", {31'd0, wr_ready_o}, 32'd0);
      for (int i = 1; i <= 8; i++) tx_handshake(8'(i));
      tx_rdy_i = 1'b1;
      tick();
      check("drained_wr_ready", {31'd0, wr_ready_o}, 32'd1);

      // Long rx_rdy pulse captures exactly one byte.
      rx_data_i = 8'h3C; rx_rdy_i = 1'b1;
      tick();
      check("rx3c_valid", {31'd0, rd_valid_o}, 32'd1);
      check("rx3c_data", {24'd0, rd_data_o}, 32'h0000_003C);
      tick(); tick();
      rx_rdy_i = 1'b0;
      rd_ready_i = 1'b1;
      tick();
      rd_ready_i = 1'b0;
      check("rx3c_single", {31'd0, rd_valid_o}, 32'd0);

      // Fill RX, overrun, clear priority, then accept-on-pop at full.
      for (int i = 0; i < 8; i++) rx_deliver(8'h10 + 8'(i), 1'b0, 1'b0);
      check("rxfull_head", {24'd0, rd_data_o}, 32'h0000_0010);
      check("rxfull_no_ovr", {31'd0, rx_overrun_o}, 32'd0);
      rx_deliver(8'h77, 1'b0, 1'b0);
      check("ovr_set", {31'd0, rx_overrun_o}, 32'd1);
      check("ovr_head_kept", {24'd0, rd_data_o}, 32'h0000_0010);
      ovr_clr_i = 1'b1;
      tick();
      ovr_clr_i = 1'b0;
      check("ovr_clear", {31'd0, rx_overrun_o}, 32'd0);
      rx_deliver(8'h78, 1'b0, 1'b1);
      check("ovr_priority", {31'd0, rx_overrun_o}, 32'd1);
      ovr_clr_i = 1'b1;
      tick();
      ovr_clr_i = 1'b0;
      check("ovr_clear_alone", {31'd0, rx_overrun_o}, 32'd0);
      rx_deliver(8'h79, 1'b1, 1'b0);
      check("popfull_no_ovr", {31'd0, rx_overrun_o}, 32'd0);
      check("popfull_head", {24'd0, rd_data_o}, 32'h0000_0011);
      for (int i = 0; i < 8; i++) begin
         check("rx_drain", {24'd0, rd_data_o}, (i < 7) ? 32'h11 + 32'(i) : 32'h79);
         rd_ready_i = 1'b1;
         tick();
         rd_ready_i = 1'b0;
      end
      check("rx_drained", {31'd0, rd_valid_o}, 32'd0);

      // Reset in TX_WAIT_HIGH with 3 bytes queued and an RX byte pending.
      rx_deliver(8'h55, 1'b0, 1'b0);
      check("pre_rst_rd_valid", {31'd0, rd_valid_o}, 32'd1);
      tx_rdy_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_valid_i = 1'b1; wr_data_i = 8'h21 + 8'(i);
         tick();
      end
      wr_valid_i = 1'b0;
      check("pre_rst_tx_data", {24'd0, tx_data_o}, 32'h0000_0021);
      tx_rdy_i = 1'b0;
      tick();
      rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
      tx_rdy_i = 1'b1;
      seen_start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (tx_start_o) seen_start = 1'b1;
      end
      check("post_rst_no_start", {31'd0, seen_start}, 32'd0);
      check("post_rst_wr_ready", {31'd0, wr_ready_o}, 32'd1);
      check("post_rst_rd_valid", {31'd0, rd_valid_o}, 32'd0);
      check("post_rst_tx_data", {24'd0, tx_data_o}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_fifo_ctrl.md
UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8: entries per FIFO; power of two, minimum 2.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high; the ports are named clk_i and rst_i.
REQ-003 The block SHALL have port clk_i  in  1  clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-005 The block SHALL have port wr_valid_i  in  1  host offers a TX byte.
REQ-006 The block SHALL have port wr_data_i  in  uart_width  TX byte from host.
REQ-007 The block SHALL have port wr_ready_o  out  1  TX FIFO not full.
REQ-008 The block SHALL have port rd_valid_o  out  1  RX FIFO not empty.
REQ-009 The block SHALL have port rd_data_o  out  uart_width  RX FIFO head byte, first-word-fall-through.
REQ-010 The block SHALL have port rd_ready_i  in  1  host consumes the RX head.
REQ-011 The block SHALL have port tx_start_o  out  1  start pulse to the UART transmitter.
REQ-012 The block SHALL have port tx_data_o  out  uart_width  byte to the UART transmitter.
REQ-013 The block SHALL have port tx_rdy_i  in  1  transmitter idle/ready level.
REQ-014 The block SHALL have port rx_data_i  in  uart_width  byte from the UART receiver.
REQ-015 The block SHALL have port rx_rdy_i  in  1  receiver byte-ready level.
REQ-016 The block SHALL have port ovr_clr_i  in  1  clears the overrun flag.
REQ-017 The block SHALL have port rx_overrun_o  out  1  sticky flag: an RX byte was dropped.

Function
REQ-018 TX push SHALL occur on a cycle where wr_valid_i and wr_ready_o are both high; RX pop SHALL occur on a cycle where rd_valid_o and rd_ready_i are both high.
REQ-019 wr_ready_o SHALL depend only on registered TX occupancy, so a pop in the same cycle does not raise it combinationally.
REQ-020 The TX FSM SHALL have states TX_IDLE, TX_START, TX_WAIT_LOW and TX_WAIT_HIGH.
REQ-021 TX_IDLE SHALL go to TX_START when the TX FIFO is non-empty and tx_rdy_i=1; otherwise it stays in TX_IDLE.
REQ-022 TX_START SHALL last exactly 1 cycle with tx_start_o=1; the TX head is popped into a tx_data_o holding register on entry.
REQ-023 TX_WAIT_LOW SHALL go to TX_WAIT_HIGH when tx_rdy_i=0.
REQ-024 TX_WAIT_HIGH SHALL go to TX_IDLE when tx_rdy_i=1.
REQ-025 tx_data_o SHALL stay stable from TX_START until the next TX_START.
REQ-026 A byte pushed into an empty TX FIFO at edge N with tx_rdy_i=1 SHALL produce tx_start_o=1 in cycle N+1.
REQ-027 tx_start_o SHALL never assert in two consecutive cycles.
REQ-028 RX capture SHALL happen only on a rising edge of rx_rdy_i, detected with a registered previous value; rx_data_i is sampled in that same cycle.
REQ-029 A captured byte SHALL make rd_valid_o=1 on the following cycle.
REQ-030 If the RX FIFO is full at capture and there is no pop in the same cycle, the byte SHALL be dropped and rx_overrun_o set to 1.
REQ-031 If the RX FIFO is full at capture and a pop occurs in the same cycle, the byte SHALL be accepted with no overrun.
REQ-032 ovr_clr_i SHALL clear rx_overrun_o; a new overrun in the same cycle takes priority and keeps it set.
REQ-033 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; counts SHALL be log2(DEPTH)+1 bits.
REQ-034 FIFO occupancy SHALL be unchanged by a simultaneous push and pop on a non-empty FIFO.

Reset
REQ-035 rst_i=1 SHALL empty both FIFOs and force the TX FSM to TX_IDLE.
REQ-036 Under reset, tx_start_o=0, tx_data_o=0, rx_overrun_o=0, rd_valid_o=0 and wr_ready_o=1.
REQ-037 The registered previous value of rx_rdy_i SHALL reset to 1, so a high level present at reset release is not captured.
REQ-038 Reset asserted mid-transmission SHALL abandon the in-flight byte and any queued bytes, with no further tx_start_o pulse.

Structure
REQ-039 uart_width SHALL come from uart_pack.
REQ-040 The TX FSM state enum tx_state_t SHALL be added to uart_pack.
REQ-041 A sub-module uart_fifo (synchronous FWFT FIFO, parameters DEPTH and width) SHALL be instantiated twice, once for TX and once for RX.
REQ-042 tx_start_o, tx_data_o and rx_data_i/rx_rdy_i SHALL connect directly to the transmitter start/data inputs and the receiver data/ready outputs of the team's UART block.

Verification
REQ-043 Reset, then push 0xA5 with tx_rdy_i=1: tx_start_o is a single pulse 1 cycle later, tx_data_o=0xA5, and wr_ready_o stays 1.
REQ-044 Push 0x01..0x08 back-to-back (DEPTH=8) while tx_rdy_i=0: wr_ready_o=0 after the 8th push; releasing tx_rdy_i handshakes yields 8 starts in order 0x01..0x08.
REQ-045 Pulse rx_rdy_i high for 3 cycles with rx_data_i=0x3C: exactly one byte 0x3C is in the RX FIFO, rd_valid_o=1 the next cycle.
REQ-046 Fill RX with 8 bytes, then deliver 0x77 with no pop: rx_overrun_o=1 and the head is still the first byte; repeat with a pop in the same cycle: 0x77 is accepted and there is no overrun.
REQ-047 Assert rst_i during TX_WAIT_HIGH with 3 bytes queued: after release, no tx_start_o, wr_ready_o=1, rd_valid_o=0.
REQ-048 Assert ovr_clr_i together with a new overrun: rx_overrun_o remains 1; ovr_clr_i alone the next cycle makes it 0.
